stream_max_tracker: RTL

//  Downstream consumer of the a-greater-than-b comparison: scans a framed stream of W-bit

---
 rtl/stream_max_tracker_pkg.sv | 13 +
 rtl/stream_max_tracker_gt.sv | 12 +
 rtl/stream_max_tracker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stream_max_tracker_pkg.sv
// Shared definitions for stream_max_tracker: FSM state encodings and default sizing.
package stream_max_tracker_pkg;

    localparam int DEFAULT_W       = 2;
    localparam int DEFAULT_MAX_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/stream_max_tracker_gt.sv
// Unsigned strict greater-than comparator, one instance per beat datapath.
module gt_comparator #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    assign gt = (a > b);

endmodule

// File: rtl/stream_max_tracker.sv
// Scans a framed valid/ready stream and reports per-frame maximum, its first index,
// the beat count and whether the frame was force-closed at MAX_LEN.
module stream_max_tracker
    import stream_max_tracker_pkg::*;
#(
    parameter  int W       = DEFAULT_W,
    parameter  int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int IW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [IW-1:0] out_index,
    output logic [IW:0]   out_count,
    output logic          out_trunc
);

    localparam int CW = IW + 1;

    state_e         state_q, state_d;
    logic [W-1:0]   max_q, max_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           trunc_q, trunc_d;

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_max_q, out_max_d;
    logic [IW-1:0]  out_index_q, out_index_d;
    logic [CW-1:0]  out_count_q, out_count_d;
    logic           out_trunc_q, out_trunc_d;

    logic           accept;
    logic           gt;
    logic           close;
    logic           at_limit;
    logic [CW-1:0]  cnt_inc;

    gt_comparator #(.W(W)) u_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (gt)
    );

    // Gating with rst_n keeps in_ready low for the whole reset assertion.
    assign in_ready = rst_n && (state_q != ST_HOLD);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CW'(1);
    assign at_limit = (cnt_inc == CW'(MAX_LEN));

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        trunc_d     = trunc_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_index_d = out_index_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        close       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = CW'(1);
                    trunc_d = 1'b0;
                    close   = in_last;
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    // Strict compare so a tie keeps the earlier index.
                    if (gt) begin
                        max_d = in_data;
                        idx_d = cnt_q[IW-1:0];
                    end
                    cnt_d   = cnt_inc;
                    trunc_d = !in_last && at_limit;
                    close   = in_last || at_limit;
                    state_d = close ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The closing beat is folded in before the result is captured.
        if (close) begin
            out_valid_d = 1'b1;
            out_max_d   = max_d;
            out_index_d = idx_d;
            out_count_d = cnt_d;
            out_trunc_d = trunc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_index_q <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            trunc_q     <= trunc_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_index_q <= out_index_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_index = out_index_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule
